// File: rtl/dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// dram_port_arbiter
//
// Purpose:
//   N-port front-end for the DRAM controller user interface. Several masters
//   (core instruction/data paths, SD-card DMA, video fetch, ...) share a single
//   controller. The block contains three pieces:
//     - a round-robin arbiter that picks the next eligible requester,
//     - a one-deep command register that holds the command until the
//       controller accepts it,
//     - an in-order read-tag FIFO that remembers which port issued each read,
//       so that returned data can be steered back to that port.
//
// Parameters:
//   NUM_PORTS       number of requesting masters (1..8)
//   ADDR_WIDTH      DRAM user address width
//   DATA_WIDTH      DRAM data width
//   MASK_WIDTH      byte-mask width (DATA_WIDTH/8)
//   RD_OUTSTANDING  maximum reads in flight (power of 2, >= 2)
//
// Ports:
//   clock, resetn              clock and asynchronous active-low reset
//   p_ren / p_wen              per-port read / write request, held until p_ack
//   p_addr/p_wdata/p_wmask     per-port command fields, port i in slice i
//   p_ack                      one-cycle pulse: request of port i captured
//   p_rvalid / p_rdata         one-cycle pulse: p_rdata belongs to port i
//   dram_ren/dram_wen          command strobes towards the controller
//   dram_addr/wdata/wmask      command fields towards the controller
//   dram_busy                  controller cannot accept a command
//   dram_rdata(_valid)         read data returned by the controller
//   dram_init_calib_complete   controller calibration done
//   ready                      registered copy of dram_init_calib_complete
//   err_orphan                 sticky: read data arrived with no read tagged
//
// Optional feature (macro DRAM_ARB_PERF_EN):
//   Adds perf_grants (one saturating 32-bit grant counter per port) and
//   perf_stall_cycles (saturating count of cycles the command register is
//   blocked by dram_busy). Without the macro these ports do not exist.
// ---------------------------------------------------------------------------
module dram_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 128,
  parameter int MASK_WIDTH     = 16,
  parameter int RD_OUTSTANDING = 4
) (
  input  logic                             clock,
  input  logic                             resetn,
  input  logic [NUM_PORTS-1:0]             p_ren,
  input  logic [NUM_PORTS-1:0]             p_wen,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  p_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  p_wdata,
  input  logic [NUM_PORTS*MASK_WIDTH-1:0]  p_wmask,
  output logic [NUM_PORTS-1:0]             p_ack,
  output logic [NUM_PORTS-1:0]             p_rvalid,
  output logic [DATA_WIDTH-1:0]            p_rdata,
  output logic                             dram_ren,
  output logic                             dram_wen,
  output logic [ADDR_WIDTH-1:0]            dram_addr,
  output logic [DATA_WIDTH-1:0]            dram_wdata,
  output logic [MASK_WIDTH-1:0]            dram_wmask,
  input  logic                             dram_busy,
  input  logic [DATA_WIDTH-1:0]            dram_rdata,
  input  logic                             dram_rdata_valid,
  input  logic                             dram_init_calib_complete,
  output logic                             ready,
  output logic                             err_orphan
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [NUM_PORTS*32-1:0]          perf_grants,
  output logic [31:0]                      perf_stall_cycles
`endif
);

  localparam int ID_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PTR_W = $clog2(RD_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ID_W-1:0]  LAST_PORT = ID_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0] RD_LIMIT  = CNT_W'(RD_OUTSTANDING);

  // Calibration status register
  logic                  ready_q, ready_d;

  // One-deep command register
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_is_read_q, cmd_is_read_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
  logic [MASK_WIDTH-1:0] cmd_wmask_q, cmd_wmask_d;
  logic [ID_W-1:0]       cmd_port_q, cmd_port_d;

  // Round-robin pointer: the port granted most recently
  logic [ID_W-1:0]       rr_q, rr_d;

  // Read-tag FIFO
  logic [ID_W-1:0]       tag_mem_q [RD_OUTSTANDING];
  logic [ID_W-1:0]       tag_mem_d [RD_OUTSTANDING];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  // Sticky orphan-data flag
  logic                  err_orphan_q, err_orphan_d;

  // Combinational helpers
  logic                  issue_ren;
  logic                  issue_wen;
  logic                  drain;
  logic                  rd_room;
  logic [NUM_PORTS-1:0]  eligible;
  logic                  capture_en;
  logic                  grant_found;
  logic [ID_W-1:0]       grant_id;
  logic                  grant_en;
  logic                  sel_is_read;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MASK_WIDTH-1:0] sel_wmask;
  logic                  fifo_empty;
  logic                  tag_push;
  logic                  tag_pop;
  logic [ID_W-1:0]       tag_head;

  // The command leaves the register the cycle the controller is not busy.
  assign issue_ren = cmd_valid_q &  cmd_is_read_q & ~dram_busy;
  assign issue_wen = cmd_valid_q & ~cmd_is_read_q & ~dram_busy;
  assign drain     = issue_ren | issue_wen;

  // A read pending in the command register already counts against the
  // outstanding limit, so the FIFO can never be pushed beyond full.
  assign rd_room  = (count_q + CNT_W'(cmd_valid_q & cmd_is_read_q)) < RD_LIMIT;
  assign eligible = p_wen | (p_ren & {NUM_PORTS{rd_room}});

  assign capture_en = ready_q & (~cmd_valid_q | drain);
  assign grant_en   = capture_en & grant_found;

  // Round-robin search: first eligible port numerically above the pointer,
  // otherwise the lowest eligible port (wrap-around). Descending loops leave
  // the lowest matching index in grant_id.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (eligible[i] && (ID_W'(i) > rr_q)) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(i);
      end
    end
    if (!grant_found) begin
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          grant_found = 1'b1;
          grant_id    = ID_W'(i);
        end
      end
    end
  end

  // Command fields of the granted port. A simultaneous read and write from
  // one port is served as the write; the read stays pending at the master.
  always_comb begin
    sel_is_read = 1'b0;
    sel_addr    = '0;
    sel_wdata   = '0;
    sel_wmask   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id == ID_W'(i)) begin
        sel_is_read = ~p_wen[i];
        sel_addr    = p_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata   = p_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_wmask   = p_wmask[i*MASK_WIDTH +: MASK_WIDTH];
      end
    end
  end

  // Next state of the command register and round-robin pointer.
  always_comb begin
    ready_d       = dram_init_calib_complete;
    cmd_valid_d   = cmd_valid_q;
    cmd_is_read_d = cmd_is_read_q;
    cmd_addr_d    = cmd_addr_q;
    cmd_wdata_d   = cmd_wdata_q;
    cmd_wmask_d   = cmd_wmask_q;
    cmd_port_d    = cmd_port_q;
    rr_d          = rr_q;
    if (grant_en) begin
      cmd_valid_d   = 1'b1;
      cmd_is_read_d = sel_is_read;
      cmd_addr_d    = sel_addr;
      cmd_wdata_d   = sel_wdata;
      cmd_wmask_d   = sel_wmask;
      cmd_port_d    = grant_id;
      rr_d          = grant_id;
    end else if (drain) begin
      cmd_valid_d   = 1'b0;
    end
  end

  // Tag FIFO control. Returned data is only routed when a tag exists;
  // otherwise it is dropped and the orphan flag latches.
  assign fifo_empty = (count_q == '0);
  assign tag_push   = issue_ren;
  assign tag_pop    = dram_rdata_valid & ~fifo_empty;
  assign tag_head   = tag_mem_q[rd_ptr_q];

  // Next state of the tag FIFO. Pointers wrap naturally because the depth
  // is a power of two; push and pop together leave the count unchanged.
  always_comb begin
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    err_orphan_d = err_orphan_q;
    if (tag_push) begin
      tag_mem_d[wr_ptr_q] = cmd_port_q;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (tag_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (tag_push && !tag_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!tag_push && tag_pop) begin
      count_d = count_q - CNT_W'(1);
    end
    if (dram_rdata_valid && fifo_empty) begin
      err_orphan_d = 1'b1;
    end
  end

  // State registers. The pointer resets to the last port so that port 0
  // wins the first arbitration after reset.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ready_q       <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_is_read_q <= 1'b0;
      cmd_addr_q    <= '0;
      cmd_wdata_q   <= '0;
      cmd_wmask_q   <= '0;
      cmd_port_q    <= '0;
      rr_q          <= LAST_PORT;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_orphan_q  <= 1'b0;
      for (int k = 0; k < RD_OUTSTANDING; k++) begin
        tag_mem_q[k] <= '0;
      end
    end else begin
      ready_q       <= ready_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_is_read_q <= cmd_is_read_d;
      cmd_addr_q    <= cmd_addr_d;
      cmd_wdata_q   <= cmd_wdata_d;
      cmd_wmask_q   <= cmd_wmask_d;
      cmd_port_q    <= cmd_port_d;
      rr_q          <= rr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_orphan_q  <= err_orphan_d;
      tag_mem_q     <= tag_mem_d;
    end
  end

  // Per-port strobes: the ack is decoded from the grant, the read-valid
  // from the FIFO head. Both are forced low while reset is asserted.
  always_comb begin
    p_ack    = '0;
    p_rvalid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      p_ack[i]    = resetn & grant_en & (grant_id == ID_W'(i));
      p_rvalid[i] = resetn & tag_pop  & (tag_head == ID_W'(i));
    end
  end

  // Remaining outputs, gated so that everything reads zero during reset.
  assign p_rdata    = resetn ? dram_rdata  : '0;
  assign dram_ren   = resetn & issue_ren;
  assign dram_wen   = resetn & issue_wen;
  assign dram_addr  = resetn ? cmd_addr_q  : '0;
  assign dram_wdata = resetn ? cmd_wdata_q : '0;
  assign dram_wmask = resetn ? cmd_wmask_q : '0;
  assign ready      = resetn & ready_q;
  assign err_orphan = resetn & err_orphan_q;

`ifdef DRAM_ARB_PERF_EN
  logic [31:0] perf_grant_q [NUM_PORTS];
  logic [31:0] perf_stall_q;

  // Saturating performance counters: grants per port and cycles in which a
  // command sits in the register while the controller is busy.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      perf_stall_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        perf_grant_q[i] <= '0;
      end
    end else begin
      if (cmd_valid_q && dram_busy && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (p_ack[i] && (perf_grant_q[i] != 32'hFFFF_FFFF)) begin
          perf_grant_q[i] <= perf_grant_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_grants = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      perf_grants[i*32 +: 32] = perf_grant_q[i];
    end
  end

  assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_dram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dram_port_arbiter
//
// Self-checking bench for dram_port_arbiter with three ports and four
// outstanding reads. A transaction-level reference model (last granted port,
// a queue of issuing port ids for reads in flight, the pending command) is
// advanced every clock and all outputs are compared against it on the
// falling edge. Directed steps exercise calibration gating, round-robin
// order, read routing, the outstanding limit, busy stalls, orphan data and
// an asynchronous reset; a randomized phase mixes everything.
// ---------------------------------------------------------------------------
module tb_dram_port_arbiter;

  localparam int N   = 3;
  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int MW  = 4;
  localparam int RDO = 4;

  logic            clock = 1'b0;
  logic            resetn;
  logic [N-1:0]    p_ren, p_wen;
  logic [N*AW-1:0] p_addr;
  logic [N*DW-1:0] p_wdata;
  logic [N*MW-1:0] p_wmask;
  logic [N-1:0]    p_ack, p_rvalid;
  logic [DW-1:0]   p_rdata;
  logic            dram_ren, dram_wen;
  logic [AW-1:0]   dram_addr;
  logic [DW-1:0]   dram_wdata;
  logic [MW-1:0]   dram_wmask;
  logic            dram_busy;
  logic [DW-1:0]   dram_rdata;
  logic            dram_rdata_valid;
  logic            dram_init_calib_complete;
  logic            ready, err_orphan;
`ifdef DRAM_ARB_PERF_EN
  logic [N*32-1:0] perf_grants;
  logic [31:0]     perf_stall_cycles;
`endif

  // Free-running clock
  always #5 clock = ~clock;

  dram_port_arbiter #(
    .NUM_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .RD_OUTSTANDING(RDO)
  ) dut (
    .clock(clock), .resetn(resetn),
    .p_ren(p_ren), .p_wen(p_wen), .p_addr(p_addr), .p_wdata(p_wdata), .p_wmask(p_wmask),
    .p_ack(p_ack), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .dram_ren(dram_ren), .dram_wen(dram_wen), .dram_addr(dram_addr),
    .dram_wdata(dram_wdata), .dram_wmask(dram_wmask), .dram_busy(dram_busy),
    .dram_rdata(dram_rdata), .dram_rdata_valid(dram_rdata_valid),
    .dram_init_calib_complete(dram_init_calib_complete),
    .ready(ready), .err_orphan(err_orphan)
`ifdef DRAM_ARB_PERF_EN
    , .perf_grants(perf_grants), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // Master and controller stimulus state
  logic [N-1:0]  reqRen, reqWen;
  logic [AW-1:0] reqAddr [N];
  logic [DW-1:0] reqData [N];
  logic [MW-1:0] reqMask [N];
  logic          busyIn, rvIn, calibIn;
  logic [DW-1:0] rdataIn;
  bit            randomMode, genNew, holdWrites;

  int checksTotal  = 0;
  int checksPassed = 0;
  int checksFailed = 0;

  // Reference model state
  bit            mReady, mCmdValid, mCmdRead, mOrphan;
  int            mCmdPort, mLast;
  logic [AW-1:0] mCmdAddr;
  logic [DW-1:0] mCmdData;
  logic [MW-1:0] mCmdMask;
  int            tagQ [$];

  // Per-cycle predictions shared between the check and the model update
  bit eGrant, eIssue, ePop;
  int eGrantPort;

  task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checksTotal++;
    assert (observed === expected) checksPassed++;
    else begin
      checksFailed++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    mReady = 0; mCmdValid = 0; mCmdRead = 0; mOrphan = 0;
    mCmdPort = 0; mLast = N - 1;
    mCmdAddr = '0; mCmdData = '0; mCmdMask = '0;
    tagQ.delete();
  endtask

  task automatic clearMasters();
    reqRen = '0; reqWen = '0;
    for (int i = 0; i < N; i++) begin
      reqAddr[i] = '0; reqData[i] = '0; reqMask[i] = '0;
    end
  endtask

  task automatic applyStimulus();
    p_ren = reqRen;
    p_wen = reqWen;
    for (int i = 0; i < N; i++) begin
      p_addr[i*AW +: AW]  = reqAddr[i];
      p_wdata[i*DW +: DW] = reqData[i];
      p_wmask[i*MW +: MW] = reqMask[i];
    end
    dram_busy                = busyIn;
    dram_rdata_valid         = rvIn;
    dram_rdata               = rdataIn;
    dram_init_calib_complete = calibIn;
  endtask

  // Predict this cycle from the model: the port after the last grant that
  // wants a write, or a read while fewer than RDO reads are committed.
  task automatic computeExpected();
    int committed;
    eIssue     = mCmdValid && !busyIn;
    committed  = tagQ.size() + ((mCmdValid && mCmdRead) ? 1 : 0);
    eGrant     = 0;
    eGrantPort = 0;
    if (mReady && (!mCmdValid || eIssue)) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (mLast + k) % N;
        if (!eGrant && (reqWen[p] || (reqRen[p] && committed < RDO))) begin
          eGrant     = 1;
          eGrantPort = p;
        end
      end
    end
    ePop = rvIn && (tagQ.size() > 0);
  endtask

  task automatic checkOutput();
    logic [N-1:0] expAck, expRv;
    @(negedge clock);
    computeExpected();
    expAck = '0;
    expRv  = '0;
    if (eGrant) expAck[eGrantPort] = 1'b1;
    if (ePop)   expRv[tagQ[0]]     = 1'b1;
    checkValue("p_ack", p_ack, expAck);
    checkValue("p_rvalid", p_rvalid, expRv);
    checkValue("dram_ren", dram_ren, eIssue && mCmdRead);
    checkValue("dram_wen", dram_wen, eIssue && !mCmdRead);
    checkValue("ready", ready, mReady);
    checkValue("err_orphan", err_orphan, mOrphan);
    if (mCmdValid) begin
      checkValue("dram_addr", dram_addr, mCmdAddr);
      if (!mCmdRead) begin
        checkValue("dram_wdata", dram_wdata, mCmdData);
        checkValue("dram_wmask", dram_wmask, mCmdMask);
      end
    end
    if (ePop) checkValue("p_rdata", p_rdata, rdataIn);
  endtask

  task automatic newRequests();
    for (int i = 0; i < N; i++) begin
      if (!reqRen[i] && !reqWen[i] && $urandom_range(0, 2) == 0) begin
        int kind;
        kind       = $urandom_range(0, 2);
        reqRen[i]  = (kind != 1);
        reqWen[i]  = (kind != 0);
        reqAddr[i] = AW'($urandom);
        reqData[i] = $urandom;
        reqMask[i] = MW'($urandom);
      end
    end
  endtask

  // Clock edge: update the model, then let masters react to their acks.
  task automatic advance();
    @(posedge clock);
    if (rvIn) begin
      if (tagQ.size() > 0) void'(tagQ.pop_front());
      else mOrphan = 1;
    end
    if (eIssue && mCmdRead) tagQ.push_back(mCmdPort);
    if (eGrant) begin
      mCmdValid = 1;
      mCmdRead  = !reqWen[eGrantPort];
      mCmdPort  = eGrantPort;
      mCmdAddr  = reqAddr[eGrantPort];
      mCmdData  = reqData[eGrantPort];
      mCmdMask  = reqMask[eGrantPort];
      mLast     = eGrantPort;
      if (reqWen[eGrantPort]) begin
        if (!holdWrites) reqWen[eGrantPort] = 1'b0;
      end else begin
        reqRen[eGrantPort] = 1'b0;
      end
    end else if (eIssue) begin
      mCmdValid = 0;
    end
    mReady = calibIn;
    if (genNew) newRequests();
    #1;
  endtask

  task automatic step();
    if (randomMode) begin
      busyIn  = ($urandom_range(0, 3) == 0);
      rvIn    = (tagQ.size() > 0) && ($urandom_range(0, 1) == 1);
      rdataIn = $urandom;
    end
    applyStimulus();
    checkOutput();
    advance();
  endtask

  task automatic runCycles(input int n);
    for (int c = 0; c < n; c++) step();
  endtask

  task automatic waitAck(input int port, input int maxCycles);
    bit got;
    got = 0;
    for (int c = 0; c < maxCycles && !got; c++) begin
      applyStimulus();
      checkOutput();
      if (p_ack[port] === 1'b1) got = 1;
      advance();
    end
    checkValue($sformatf("ack_wait_p%0d", port), got, 1);
  endtask

  task automatic drainReads();
    for (int c = 0; c < 32; c++) begin
      if (tagQ.size() == 0 && !mCmdValid) break;
      rvIn    = (tagQ.size() > 0);
      rdataIn = $urandom;
      step();
    end
    rvIn = 0;
  endtask

  initial begin
    logic [DW-1:0] dataA, dataB;
    randomMode = 0; genNew = 0; holdWrites = 0;
    busyIn = 0; rvIn = 0; calibIn = 0; rdataIn = '0;
    clearMasters();
    modelReset();
    resetn = 1'b0;
    applyStimulus();

    // Reset state
    #12;
    checkValue("rst_ack", p_ack, 0);
    checkValue("rst_dram_ren", dram_ren, 0);
    checkValue("rst_ready", ready, 0);
    checkValue("rst_orphan", err_orphan, 0);
    @(posedge clock); #1;
    resetn = 1'b1;

    // Calibration gating: a read waits 20 cycles without ack or issue
    reqRen[0] = 1'b1; reqAddr[0] = 16'h0040;
    runCycles(20);
    calibIn = 1'b1;
    applyStimulus(); checkOutput();
    checkValue("calib_no_ack_yet", p_ack, 0);
    advance();
    applyStimulus(); checkOutput();
    checkValue("calib_ack", p_ack, 3'b001);
    checkValue("calib_no_ren_yet", dram_ren, 0);
    advance();
    applyStimulus(); checkOutput();
    checkValue("calib_ren", dram_ren, 1);
    checkValue("calib_addr", dram_addr, 16'h0040);
    advance();
    drainReads();

    // Round-robin: point at port 2 first so the order starts at port 0
    reqWen[2] = 1'b1; reqAddr[2] = 16'h0222; reqData[2] = 32'h2222_0000; reqMask[2] = 4'hF;
    waitAck(2, 8);
    holdWrites = 1;
    for (int i = 0; i < N; i++) begin
      reqWen[i] = 1'b1; reqAddr[i] = AW'(16'h0300 + i); reqData[i] = 32'hA000_0000 + i; reqMask[i] = MW'(i + 1);
    end
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] want;
      want = '0;
      want[k % N] = 1'b1;
      applyStimulus(); checkOutput();
      checkValue($sformatf("rr_ack_%0d", k), p_ack, want);
      checkValue($sformatf("rr_wen_%0d", k), dram_wen, 1);
      advance();
    end
    holdWrites = 0;
    reqWen = '0;
    runCycles(2);

    // Read routing: port 1 then port 0, data returns in issue order
    reqRen[1] = 1'b1; reqAddr[1] = 16'h0100;
    waitAck(1, 8);
    reqRen[0] = 1'b1; reqAddr[0] = 16'h0200;
    waitAck(0, 8);
    runCycles(2);
    dataA = 32'hAAAA_0001; dataB = 32'hBBBB_0002;
    rvIn = 1'b1; rdataIn = dataA;
    applyStimulus(); checkOutput();
    checkValue("route_A_valid", p_rvalid, 3'b010);
    checkValue("route_A_data", p_rdata, dataA);
    advance();
    rdataIn = dataB;
    applyStimulus(); checkOutput();
    checkValue("route_B_valid", p_rvalid, 3'b001);
    checkValue("route_B_data", p_rdata, dataB);
    advance();
    rvIn = 1'b0;

    // Outstanding limit: four reads in flight block a fifth, not a write
    for (int r = 0; r < RDO; r++) begin
      reqRen[0] = 1'b1; reqAddr[0] = AW'(16'h0400 + r);
      waitAck(0, 8);
    end
    runCycles(1);
    reqRen[0] = 1'b1; reqAddr[0] = 16'h0500;
    reqWen[1] = 1'b1; reqAddr[1] = 16'h0600; reqData[1] = 32'h6666_6666; reqMask[1] = 4'h3;
    applyStimulus(); checkOutput();
    checkValue("limit_write_ack", p_ack, 3'b010);
    advance();
    applyStimulus(); checkOutput();
    checkValue("limit_read_blocked", p_ack, 3'b000);
    advance();
    rvIn = 1'b1; rdataIn = 32'h1234_5678;
    applyStimulus(); checkOutput();
    checkValue("limit_pop_route", p_rvalid, 3'b001);
    advance();
    rvIn = 1'b0;
    applyStimulus(); checkOutput();
    checkValue("limit_read_ack", p_ack, 3'b001);
    advance();
    drainReads();

    // Busy stall: captured write holds its fields and issues once busy drops
    busyIn = 1'b1;
    reqWen[2] = 1'b1; reqAddr[2] = 16'h0ABC; reqData[2] = 32'hCAFE_F00D; reqMask[2] = 4'h9;
    waitAck(2, 8);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(); checkOutput();
      checkValue("stall_wen", dram_wen, 0);
      checkValue("stall_addr", dram_addr, 16'h0ABC);
      checkValue("stall_wdata", dram_wdata, 32'hCAFE_F00D);
      advance();
    end
    busyIn = 1'b0;
    applyStimulus(); checkOutput();
    checkValue("stall_release_wen", dram_wen, 1);
    advance();

    // Randomized traffic against the model
    randomMode = 1; genNew = 1;
    runCycles(400);
    genNew = 0;
    for (int c = 0; c < 200; c++) begin
      if (reqRen == '0 && reqWen == '0) break;
      step();
    end
    randomMode = 0;
    clearMasters();
    busyIn = 1'b0;
    drainReads();
    runCycles(1);

    // Orphan data: dropped, no routing, sticky flag
    rvIn = 1'b1; rdataIn = 32'hDEAD_BEEF;
    applyStimulus(); checkOutput();
    checkValue("orphan_no_rvalid", p_rvalid, 0);
    advance();
    rvIn = 1'b0;
    applyStimulus(); checkOutput();
    checkValue("orphan_flag", err_orphan, 1);
    advance();

    // Asynchronous reset with two reads in flight
    reqRen[1] = 1'b1; reqAddr[1] = 16'h0701;
    waitAck(1, 8);
    reqRen[2] = 1'b1; reqAddr[2] = 16'h0702;
    waitAck(2, 8);
    runCycles(1);
    reqWen[0] = 1'b1; reqAddr[0] = 16'h0770; reqData[0] = 32'h7777_0000; reqMask[0] = 4'hF;
    rvIn = 1'b1; rdataIn = 32'h5555_AAAA;
    applyStimulus();
    #2;
    resetn = 1'b0;
    #1;
    checkValue("arst_ack", p_ack, 0);
    checkValue("arst_rvalid", p_rvalid, 0);
    checkValue("arst_rdata", p_rdata, 0);
    checkValue("arst_ren", dram_ren, 0);
    checkValue("arst_wen", dram_wen, 0);
    checkValue("arst_addr", dram_addr, 0);
    checkValue("arst_wdata", dram_wdata, 0);
    checkValue("arst_wmask", dram_wmask, 0);
    checkValue("arst_ready", ready, 0);
    checkValue("arst_orphan", err_orphan, 0);
    modelReset();
    clearMasters();
    rvIn = 1'b0;
    applyStimulus();
    @(posedge clock); #1;
    resetn = 1'b1;
    rvIn = 1'b1; rdataIn = 32'h0BAD_0BAD;
    step();
    rvIn = 1'b0;
    reqRen = 3'b111;
    for (int i = 0; i < N; i++) reqAddr[i] = AW'(16'h0800 + i);
    applyStimulus(); checkOutput();
    checkValue("post_rst_orphan", err_orphan, 1);
    checkValue("post_rst_first_ack", p_ack, 3'b001);
    advance();
    runCycles(4);
    drainReads();

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

  // Absolute time limit so the bench always terminates
  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed running expected finished");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
